// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch queue.
package fetch_pkg;

  localparam int FETCH_WIDTH = 32;
  localparam int FETCH_AW    = 8;
  localparam int FETCH_DEPTH = 4;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] instr;
    logic [FETCH_AW-1:0]    pc;
  } fetch_entry_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/flush and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = FETCH_DEPTH,
  parameter type T     = fetch_entry_t
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic                      i_flush,
  input  logic [$bits(T)-1:0]       i_data,
  output logic [$bits(T)-1:0]       o_head,
  output logic [ptr_width(DEPTH):0] o_count
);

  localparam int PW = ptr_width(DEPTH);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [PW:0]   r_count;

  // Flush takes priority over any push or pop in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (i_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wrPtr] <= T'(i_data);
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

  // The issue logic reserves a slot before every read, so a full push is a design bug.
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_flush && r_count == (PW+1)'(DEPTH)));

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues imem reads from the PC, queues responses, hands them to decode.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = FETCH_WIDTH,
  parameter int AW    = FETCH_AW,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    pc,
  input  logic             FlushF,
  output logic             StallF,
  output logic             imem_en,
  output logic [AW-1:0]    imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             valid_d,
  input  logic             ready_d,
  output logic [WIDTH-1:0] instr_d,
  output logic [AW-1:0]    pc_d
);

  localparam int CW = ptr_width(DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [AW-1:0]    pc;
  } entry_t;

  logic          r_inflight;
  logic [AW-1:0] r_inflightPc;

  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_bypass;
  logic          w_pop;
  logic          w_fifoPop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_occupancy;
  entry_t        w_entryIn;
  entry_t        w_head;

  assign w_empty = (w_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && r_inflight && !FlushF;
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    valid_d = 1'b0;
    instr_d = '0;
    pc_d    = '0;
    if (w_bypass) begin
      valid_d = 1'b1;
      instr_d = imem_rdata;
      pc_d    = r_inflightPc;
    end else if (!w_empty) begin
      valid_d = 1'b1;
      instr_d = w_head.instr;
      pc_d    = w_head.pc;
    end
  end

  assign w_pop     = valid_d && ready_d;
  assign w_fifoPop = w_pop && !w_empty;
  // A bypassed response that decode takes this cycle never occupies a slot.
  assign w_push    = r_inflight && !FlushF && !(w_bypass && ready_d);

  assign w_occupancy = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_issue     = reset && !FlushF && (w_occupancy < (CW+1)'(DEPTH));

  assign imem_en   = w_issue;
  assign imem_addr = pc;
  assign StallF    = reset && !w_issue && !FlushF;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight   <= 1'b0;
      r_inflightPc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflightPc <= pc;
    end
  end

  assign w_entryIn.instr = imem_rdata;
  assign w_entryIn.pc    = r_inflightPc;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_pop   (w_fifoPop),
    .i_flush (FlushF),
    .i_data  (w_entryIn),
    .o_head  (w_head),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
// Honours FETCH_QUEUE_BYPASS_EN so the same bench covers both builds.
module tb_fetch_queue;

  localparam int WIDTH = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [AW-1:0]    pc;
  logic             FlushF;
  logic             StallF;
  logic             imem_en;
  logic [AW-1:0]    imem_addr;
  logic [WIDTH-1:0] imemRdata;
  logic             valid_d;
  logic             ready_d;
  logic [WIDTH-1:0] instr_d;
  logic [AW-1:0]    pc_d;

  int total = 0;
  int bad   = 0;

  // Reference model: PCs whose reads were pushed, plus the single read in flight.
  logic [AW-1:0] mq[$];
  bit            mInflight;
  logic [AW-1:0] mInflightPc;
  logic [AW-1:0] pcReg;

  int cycleNo;
  int firstEn;
  int firstValid;
  int enSeen;
  bit armFlush;
  int postFlushPc;

  fetch_queue #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .FlushF     (FlushF),
    .StallF     (StallF),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imemRdata),
    .valid_d    (valid_d),
    .ready_d    (ready_d),
    .instr_d    (instr_d),
    .pc_d       (pc_d)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] memf(input logic [AW-1:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'h3C};
  endfunction

  // Instruction memory: 1-cycle latency, garbage when not enabled.
  always @(posedge clk) begin
    imemRdata <= imem_en ? memf(imem_addr) : WIDTH'($urandom);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit flush, input bit rdy);
    FlushF  = flush;
    ready_d = rdy;
    pc      = pcReg;
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic stepCycle(input bit flush, input bit rdy, input logic [AW-1:0] target);
    bit            bypass;
    bit            expValid;
    bit            hasQ;
    bit            pop;
    bit            issue;
    logic [AW-1:0] headPc;
    applyStimulus(flush, rdy);
    @(negedge clk);
    hasQ   = (mq.size() != 0);
    bypass = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = !hasQ && mInflight && !flush;
`endif
    expValid = hasQ || bypass;
    headPc   = hasQ ? mq[0] : (bypass ? mInflightPc : '0);
    pop      = expValid && rdy;
    issue    = !flush && ((mq.size() + int'(mInflight) - int'(pop)) < DEPTH);
    checkOutput("valid_d", valid_d, expValid);
    checkOutput("pc_d", pc_d, headPc);
    checkOutput("instr_d", instr_d, expValid ? memf(headPc) : '0);
    checkOutput("imem_en", imem_en, issue);
    checkOutput("StallF", StallF, !issue && !flush);
    checkOutput("imem_addr", imem_addr, pcReg);
    if (imem_en === 1'b1) enSeen++;
    if (imem_en === 1'b1 && firstEn < 0) firstEn = cycleNo;
    if (valid_d === 1'b1 && firstValid < 0) firstValid = cycleNo;
    if (armFlush && !flush && valid_d === 1'b1) begin
      postFlushPc = int'(pc_d);
      armFlush    = 1'b0;
    end
    cycleNo++;
    if (pop && hasQ) void'(mq.pop_front());
    if (mInflight && !flush && !(bypass && rdy)) mq.push_back(mInflightPc);
    if (flush) mq.delete();
    mInflight   = issue;
    mInflightPc = pcReg;
    if (flush)      pcReg = target;
    else if (issue) pcReg = pcReg + AW'(4);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset entered and left away from any clock edge.
  task automatic doReset(input string tag);
    reset = 1'b0;
    #1;
    checkOutput({tag, "_valid_d"}, valid_d, 1'b0);
    checkOutput({tag, "_imem_en"}, imem_en, 1'b0);
    checkOutput({tag, "_StallF"}, StallF, 1'b0);
    checkOutput({tag, "_instr_d"}, instr_d, '0);
    checkOutput({tag, "_pc_d"}, pc_d, '0);
    mq.delete();
    mInflight = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    FlushF = 1'b0;
    ready_d = 1'b0;
    pcReg = '0;
    pc = '0;
    mInflight = 1'b0;
    mInflightPc = '0;
    armFlush = 1'b0;
    postFlushPc = -1;
    cycleNo = 0;
    firstEn = -1;
    firstValid = -1;
    enSeen = 0;
    @(posedge clk);
    #1;

    $display("[TB] streaming with decode ready");
    doReset("rst0");
    for (int i = 0; i < 10; i++) stepCycle(1'b0, 1'b1, '0);
    checkOutput("first_issue_cycle", 64'(firstEn), 64'd0);
    checkOutput("issue_to_valid_latency", 64'(firstValid - firstEn), 64'(LAT));

    $display("[TB] decode stalled, then drained");
    pcReg = '0;
    doReset("rst1");
    enSeen = 0;
    for (int i = 0; i < 10; i++) stepCycle(1'b0, 1'b0, '0);
    checkOutput("stalled_issue_count", 64'(enSeen), 64'(DEPTH));
    for (int i = 0; i < 8; i++) stepCycle(1'b0, 1'b1, '0);

    $display("[TB] redirect with a full pipeline");
    pcReg = '0;
    doReset("rst2");
    for (int i = 0; i < 4; i++) stepCycle(1'b0, 1'b0, '0);
    armFlush = 1'b1;
    stepCycle(1'b1, 1'b0, 8'h40);
    for (int i = 0; i < 6; i++) stepCycle(1'b0, 1'b1, '0);
    checkOutput("post_redirect_pc", 64'(postFlushPc), 64'h40);

    $display("[TB] bypass target at 0x10");
    pcReg = 8'h10;
    doReset("rst3");
    for (int i = 0; i < 4; i++) stepCycle(1'b0, 1'b1, '0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++)
      stepCycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                AW'($urandom) & 8'hFC);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 5; i++) stepCycle(1'b0, 1'b1, '0);
    doReset("rst4");
    for (int i = 0; i < 8; i++) stepCycle(1'b0, $urandom_range(0, 1) != 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
